// File: rtl/right_shift_variable_pipelined_if.sv
// Operand/result bundle for the pipelined variable right shifter.
// master drives operands and observes results; slave is the shifter side.
interface right_shift_variable_pipelined_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic          arg_vld;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic          arith;
  logic          res_vld;
  logic [N-1:0]  res;

  modport master (
    output arg_vld, a, shamt, arith,
    input  res_vld, res
  );

  modport slave (
    input  arg_vld, a, shamt, arith,
    output res_vld, res
  );
endinterface

// File: rtl/right_shift_variable_pipelined.sv
// Logarithmic barrel right shifter (logical/arithmetic), one registered stage per shamt bit.
// Latency SW cycles, one operation per cycle, no backpressure; res holds the last result when idle.
module right_shift_variable_pipelined #(
  parameter int N = 8
) (
  input logic                             clk,
  input logic                             rst,
  right_shift_variable_pipelined_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0]  r_dat  [SW];
  logic          r_vld  [SW];
  logic [SW-1:0] r_sh   [SW];
  logic          r_fill [SW];

  logic [N-1:0]  w_in_dat  [SW];
  logic          w_in_vld  [SW];
  logic [SW-1:0] w_in_sh   [SW];
  logic          w_in_fill [SW];
  logic [N-1:0]  w_shf     [SW];

  // The remaining shamt is shifted down one bit per stage, so each stage
  // always consumes bit 0 of what it receives.
  always_comb begin
    w_in_dat[0]  = bus.a;
    w_in_vld[0]  = bus.arg_vld;
    w_in_sh[0]   = bus.shamt;
    w_in_fill[0] = bus.arith & bus.a[N-1];
    for (int k = 1; k < SW; k++) begin
      w_in_dat[k]  = r_dat[k-1];
      w_in_vld[k]  = r_vld[k-1];
      w_in_sh[k]   = r_sh[k-1];
      w_in_fill[k] = r_fill[k-1];
    end
    for (int k = 0; k < SW; k++) begin
      if (w_in_sh[k][0]) begin
        w_shf[k] = ({N{w_in_fill[k]}} << (N - (1 << k))) | (w_in_dat[k] >> (1 << k));
      end else begin
        w_shf[k] = w_in_dat[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SW; k++) begin
        r_vld[k]  <= 1'b0;
        r_dat[k]  <= '0;
        r_sh[k]   <= '0;
        r_fill[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SW; k++) begin
        // Valid always advances so bubbles propagate; payload only on valid.
        r_vld[k] <= w_in_vld[k];
        if (w_in_vld[k]) begin
          r_dat[k]  <= w_shf[k];
          r_sh[k]   <= w_in_sh[k] >> 1;
          r_fill[k] <= w_in_fill[k];
        end
      end
    end
  end

  assign bus.res     = r_dat[SW-1];
  assign bus.res_vld = r_vld[SW-1];
endmodule

// File: tb/tb_right_shift_variable_pipelined.sv
// Self-checking bench: directed table at N=8, exhaustive N=8 and random N=32 streams,
// hold, bubble and asynchronous reset sequences, with a golden-model delay-line monitor.
module tb_right_shift_variable_pipelined;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  right_shift_variable_pipelined_if #(.N(8))  bus8 ();
  right_shift_variable_pipelined_if #(.N(32)) bus32 ();

  right_shift_variable_pipelined #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  right_shift_variable_pipelined #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  function automatic logic [7:0] g8(input logic [7:0] a, input logic [2:0] s, input logic ar);
    if (ar) g8 = $signed(a) >>> s;
    else    g8 = a >> s;
  endfunction

  function automatic logic [31:0] g32(input logic [31:0] a, input logic [4:0] s, input logic ar);
    if (ar) g32 = $signed(a) >>> s;
    else    g32 = a >> s;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Golden results delayed by the pipeline depth; hold register tracks last valid result.
  logic       m8_v [3];
  logic [7:0] m8_d [2];
  logic [7:0] m8_hold;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) m8_v[i] <= 1'b0;
      for (int i = 0; i < 2; i++) m8_d[i] <= '0;
      m8_hold <= '0;
    end else begin
      m8_v[0] <= bus8.arg_vld;
      m8_d[0] <= g8(bus8.a, bus8.shamt, bus8.arith);
      for (int i = 1; i < 3; i++) m8_v[i] <= m8_v[i-1];
      m8_d[1] <= m8_d[0];
      if (m8_v[1]) m8_hold <= m8_d[1];
    end
  end

  logic        m32_v [5];
  logic [31:0] m32_d [4];
  logic [31:0] m32_hold;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) m32_v[i] <= 1'b0;
      for (int i = 0; i < 4; i++) m32_d[i] <= '0;
      m32_hold <= '0;
    end else begin
      m32_v[0] <= bus32.arg_vld;
      m32_d[0] <= g32(bus32.a, bus32.shamt, bus32.arith);
      for (int i = 1; i < 5; i++) m32_v[i] <= m32_v[i-1];
      for (int i = 1; i < 4; i++) m32_d[i] <= m32_d[i-1];
      if (m32_v[3]) m32_hold <= m32_d[3];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mon8_vld",  {63'd0, bus8.res_vld},  {63'd0, m8_v[2]});
      check("mon8_res",  {56'd0, bus8.res},      {56'd0, m8_hold});
      check("mon32_vld", {63'd0, bus32.res_vld}, {63'd0, m32_v[4]});
      check("mon32_res", {32'd0, bus32.res},     {32'd0, m32_hold});
    end
  end

  task automatic drive8(input logic v, input logic [7:0] a, input logic [2:0] s, input logic ar);
    bus8.arg_vld = v;
    bus8.a       = a;
    bus8.shamt   = s;
    bus8.arith   = ar;
  endtask

  task automatic drive32(input logic v, input logic [31:0] a, input logic [4:0] s, input logic ar);
    bus32.arg_vld = v;
    bus32.a       = a;
    bus32.shamt   = s;
    bus32.arith   = ar;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [2:0] sh;
    logic       ar;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [14];
  logic [7:0] last8;
  logic [7:0] tmp_a;
  logic [2:0] tmp_s;
  logic       tmp_r;

  initial begin
    tbl[0]  = '{8'hB4, 3'd3, 1'b0, 8'h16};
    tbl[1]  = '{8'hB4, 3'd3, 1'b1, 8'hF6};
    tbl[2]  = '{8'h80, 3'd7, 1'b1, 8'hFF};
    tbl[3]  = '{8'h5A, 3'd0, 1'b0, 8'h5A};
    tbl[4]  = '{8'h5A, 3'd0, 1'b1, 8'h5A};
    tbl[5]  = '{8'h80, 3'd7, 1'b0, 8'h01};
    tbl[6]  = '{8'hFF, 3'd4, 1'b0, 8'h0F};
    tbl[7]  = '{8'hFF, 3'd4, 1'b1, 8'hFF};
    tbl[8]  = '{8'h7F, 3'd7, 1'b1, 8'h00};
    tbl[9]  = '{8'h7F, 3'd1, 1'b1, 8'h3F};
    tbl[10] = '{8'hC3, 3'd1, 1'b0, 8'h61};
    tbl[11] = '{8'hC3, 3'd2, 1'b1, 8'hF0};
    tbl[12] = '{8'h96, 3'd5, 1'b1, 8'hFC};
    tbl[13] = '{8'h96, 3'd6, 1'b0, 8'h02};

    rst = 1'b1;
    drive8(1'b0, 8'h00, 3'd0, 1'b0);
    drive32(1'b0, 32'h0, 5'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rst8_vld",  {63'd0, bus8.res_vld},  64'd0);
    check("rst8_res",  {56'd0, bus8.res},      64'd0);
    check("rst32_vld", {63'd0, bus32.res_vld}, 64'd0);
    check("rst32_res", {32'd0, bus32.res},     64'd0);
    chk_en = 1'b1;

    // Release reset on a negedge with the first operand already valid.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive8(1'b1, tbl[i].a, tbl[i].sh, tbl[i].ar);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        if (c < 3) begin
          check($sformatf("tbl%0d_early_vld%0d", i, c), {63'd0, bus8.res_vld}, 64'd0);
        end else begin
          check($sformatf("tbl%0d_vld", i), {63'd0, bus8.res_vld}, 64'd1);
          check($sformatf("tbl%0d_res", i), {56'd0, bus8.res}, {56'd0, tbl[i].exp});
        end
        drive8(1'b0, 8'($urandom), 3'($urandom), 1'($urandom));
      end
    end
    last8 = tbl[13].exp;

    // Streaming: 10 valid, one bubble, 10 valid, then idle.
    for (int i = 0; i < 26; i++) begin
      tmp_a = 8'($urandom);
      tmp_s = 3'($urandom);
      tmp_r = 1'($urandom);
      if (i == 10 || i >= 21) begin
        drive8(1'b0, tmp_a, tmp_s, tmp_r);
      end else begin
        drive8(1'b1, tmp_a, tmp_s, tmp_r);
        last8 = g8(tmp_a, tmp_s, tmp_r);
      end
      @(negedge clk);
    end

    // Hold: toggling inputs with arg_vld low must leave res untouched.
    for (int i = 0; i < 10; i++) begin
      drive8(1'b0, 8'($urandom), 3'($urandom), 1'($urandom));
      @(negedge clk);
      check("hold_vld", {63'd0, bus8.res_vld}, 64'd0);
      check("hold_res", {56'd0, bus8.res}, {56'd0, last8});
    end

    // Reset mid-flight with two operands in the pipe.
    drive8(1'b1, 8'hB4, 3'd1, 1'b1);
    drive32(1'b1, 32'hDEAD_BEEF, 5'd4, 1'b1);
    @(negedge clk);
    drive8(1'b1, 8'h7E, 3'd2, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst8_vld",  {63'd0, bus8.res_vld},  64'd0);
    check("mid_rst8_res",  {56'd0, bus8.res},      64'd0);
    check("mid_rst32_vld", {63'd0, bus32.res_vld}, 64'd0);
    check("mid_rst32_res", {32'd0, bus32.res},     64'd0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 3'd0, 1'b0);
    drive32(1'b0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst8_vld",  {63'd0, bus8.res_vld},  64'd0);
      check("post_rst32_vld", {63'd0, bus32.res_vld}, 64'd0);
    end

    // Exhaustive N=8 stream alongside random N=32 traffic with periodic bubbles.
    for (int i = 0; i < 4096; i++) begin
      tmp_a = i[7:0];
      tmp_s = i[10:8];
      tmp_r = i[11];
      drive8(1'b1, tmp_a, tmp_s, tmp_r);
      drive32((i % 7) != 3, $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
      @(negedge clk);
    end
    drive8(1'b0, 8'h00, 3'd0, 1'b0);
    drive32(1'b0, 32'h0, 5'd0, 1'b0);
    repeat (8) @(negedge clk);
    check("final8_res", {56'd0, bus8.res}, {56'd0, g8(8'hFF, 3'd7, 1'b1)});

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
